// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared definitions for the round-robin mux arbiter.
//   state_e   : arbiter FSM states (IDLE, GRANT)
//   NUM_SRC   : number of request sources (4)
//   SEL_W     : width of the encoded source index (2)
//   rr_pick() : round-robin search helper
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns the first requesting index found when searching upward from ptr,
  // wrapping 3->0. The loop runs from the farthest offset down to offset 0,
  // so the nearest requester is the one left in pick. The index arithmetic
  // is SEL_W bits wide, which gives the wrap for free.
  // With req == 0 the result is ptr; callers only use it when |req.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_if -- bundle of request, data and grant signals around the
// arbiter.
//   req[3:0]        : request per source
//   din0..din3      : source data, DATA_W bits each
//   out_ready       : downstream accepts dout
//   gnt[3:0]        : one-hot grant, zero when idle
//   sel[1:0]        : registered mux select
//   dout            : selected source data
//   out_valid       : dout holds a valid beat
// Modports: slave  = arbiter side (consumes req/din/out_ready)
//           master = environment side (drives req/din/out_ready)
// ---------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 2
);
  import arb_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [DATA_W-1:0]  din0;
  logic [DATA_W-1:0]  din1;
  logic [DATA_W-1:0]  din2;
  logic [DATA_W-1:0]  din3;
  logic               out_ready;
  logic [NUM_SRC-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  dout;
  logic               out_valid;

  modport slave (
    input  req, din0, din1, din2, din3, out_ready,
    output gnt, sel, dout, out_valid
  );

  modport master (
    output req, din0, din1, din2, din3, out_ready,
    input  gnt, sel, dout, out_valid
  );

endinterface

// File: rtl/mux4_data.sv
// ---------------------------------------------------------------------------
// mux4_data -- 4:1 data multiplexer, purely combinational.
//   sel[1:0]   : source index
//   din0..din3 : source data, DATA_W bits each
//   dout       : din[sel]
// ---------------------------------------------------------------------------
module mux4_data
  import arb_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] src [NUM_SRC];

  assign src[0] = din0;
  assign src[1] = din1;
  assign src[2] = din2;
  assign src[3] = din3;

  assign dout = src[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter -- 4-source round-robin arbiter with an output data mux.
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rr_mux_arbiter_if.slave (req, din0..3, out_ready in;
//            gnt, sel, dout, out_valid out)
// Each grant lasts one beat by default. Defining ARB_BURST_EN lets a grant
// run up to MAX_BURST beats while the granted source keeps requesting.
// ---------------------------------------------------------------------------
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("rr_mux_arbiter: MAX_BURST must be at least 1");
  end

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   pick;
  logic               xfer;
  logic               burst_more;

  // out_valid is exactly "in GRANT", so a transfer is GRANT plus ready.
  assign xfer = (state_q == GRANT) && bus.out_ready;
  assign pick = rr_pick(bus.req, ptr_q);

`ifdef ARB_BURST_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts the beats already taken in this grant. The grant continues
  // only while the owner still requests and the limit is not reached.
  assign burst_more = bus.req[sel_q] && (cnt_q < CNT_W'(MAX_BURST - 1));
`else
  assign burst_more = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
`ifdef ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = pick;
          gnt_d   = NUM_SRC'(1) << pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (burst_more) begin
`ifdef ARB_BURST_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end else begin
            // Priority moves past the source just served.
            ptr_d   = sel_q + SEL_W'(1);
            gnt_d   = '0;
            state_d = IDLE;
`ifdef ARB_BURST_EN
            cnt_d   = '0;
`endif
          end
        end else if (!bus.req[sel_q]) begin
          // The owner withdrew before its beat was taken. ptr is left as is,
          // so that source is still first in line when it requests again.
          gnt_d   = '0;
          state_d = IDLE;
`ifdef ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
`ifdef ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
`ifdef ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state_q == GRANT);

  mux4_data #(
    .DATA_W (DATA_W)
  ) u_mux (
    .sel  (sel_q),
    .din0 (bus.din0),
    .din1 (bus.din1),
    .din2 (bus.din2),
    .din3 (bus.din3),
    .dout (bus.dout)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter -- directed bench for rr_mux_arbiter.
// Inputs are driven 1 time unit after a rising edge. Outputs are checked 1 time
// unit later, well away from any edge. Expected values are hand-computed. The
// burst section follows ARB_BURST_EN. Every other section expects one beat per
// grant.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.DATA_W(2)) bus ();

  rr_mux_arbiter #(
    .DATA_W    (2),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits 1 time unit so combinational dout settles, then checks the outputs.
  // sel and dout are only meaningful while out_valid is high.
  task automatic exp_out(input string tag, input logic [3:0] g, input logic ov,
                         input logic [1:0] s, input logic [1:0] d);
    #1;
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
      chk({tag, "_dout"}, 32'(bus.dout), 32'(d));
    end
  endtask

  logic [3:0] rr_gnt [9];
  logic [1:0] rr_sel [9];
  logic [2:0] lo;

  initial begin
    rr_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rr_sel = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};

    // Reset state.
    rst_n         = 1'b0;
    bus.req       = 4'b0000;
    bus.out_ready = 1'b0;
    bus.din0      = 2'b00;
    bus.din1      = 2'b01;
    bus.din2      = 2'b10;
    bus.din3      = 2'b11;
    #3;
    exp_out("reset", 4'b0000, 1'b0, 2'd0, 2'd0);
    chk("reset_sel", 32'(bus.sel), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    exp_out("reset_release", 4'b0000, 1'b0, 2'd0, 2'd0);

    // Two requesters, one idle cycle between their grants.
    bus.req       = 4'b0101;
    bus.out_ready = 1'b1;
    cyc(); exp_out("t1_g0", 4'b0001, 1'b1, 2'd0, 2'b00);
    cyc(); exp_out("t1_idle", 4'b0000, 1'b0, 2'd0, 2'd0);
    cyc(); exp_out("t1_g2", 4'b0100, 1'b1, 2'd2, 2'b10);
    bus.req = 4'b0000;
    cyc(); exp_out("t1_end", 4'b0000, 1'b0, 2'd0, 2'd0);

    // All four requesting: grant order 0,1,2,3,0 with idle cycles in between.
    // A reset pulse between clock edges brings ptr back to 0 first.
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      cyc();
      exp_out($sformatf("t2_step%0d", i), rr_gnt[i], (rr_gnt[i] != 4'b0000),
              rr_sel[i], rr_sel[i]);
    end
    cyc();
    bus.req = 4'b0000;
    exp_out("t2_end", 4'b0000, 1'b0, 2'd0, 2'd0);

    // Source 3 is held off by out_ready for 5 cycles. Other req bits toggle
    // meanwhile. The next grant then wraps to source 0.
    bus.req       = 4'b1000;
    bus.out_ready = 1'b0;
    cyc(); exp_out("t3_g3", 4'b1000, 1'b1, 2'd3, 2'b11);
    for (int i = 0; i < 5; i++) begin
      lo      = 3'(i + 1);
      bus.req = {1'b1, lo};
      cyc();
      exp_out($sformatf("t3_hold%0d", i), 4'b1000, 1'b1, 2'd3, 2'b11);
    end
    bus.out_ready = 1'b1;
    cyc(); exp_out("t3_xfer", 4'b0000, 1'b0, 2'd0, 2'd0);
    bus.req = 4'b1111;
    cyc(); exp_out("t3_wrap", 4'b0001, 1'b1, 2'd0, 2'b00);
    bus.req = 4'b0000;
    cyc(); exp_out("t3_end", 4'b0000, 1'b0, 2'd0, 2'd0);

    // Source 1 withdraws before its beat. It is regranted first afterwards.
    bus.req       = 4'b0010;
    bus.out_ready = 1'b0;
    cyc(); exp_out("t4_g1", 4'b0010, 1'b1, 2'd1, 2'b01);
    bus.req = 4'b0000;
    cyc(); exp_out("t4_abort", 4'b0000, 1'b0, 2'd0, 2'd0);
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    cyc(); exp_out("t4_regrant", 4'b0010, 1'b1, 2'd1, 2'b01);
    cyc(); exp_out("t4_end", 4'b0000, 1'b0, 2'd0, 2'd0);

    // Asynchronous reset in the middle of a grant.
    bus.out_ready = 1'b0;
    cyc(); exp_out("t5_g2", 4'b0100, 1'b1, 2'd2, 2'b10);
    #1;
    rst_n = 1'b0;
    exp_out("t5_async", 4'b0000, 1'b0, 2'd0, 2'd0);
    chk("t5_async_sel", 32'(bus.sel), 32'd0);
    cyc();
    bus.req       = 4'b0110;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    cyc(); exp_out("t5_first", 4'b0010, 1'b1, 2'd1, 2'b01);
    bus.req = 4'b0000;
    cyc(); exp_out("t5_end", 4'b0000, 1'b0, 2'd0, 2'd0);

    // Source 2 requests continuously.
    bus.req = 4'b0100;
`ifdef ARB_BURST_EN
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_out($sformatf("t6_beat%0d", i), 4'b0100, 1'b1, 2'd2, 2'b10);
    end
    cyc(); exp_out("t6_idle", 4'b0000, 1'b0, 2'd0, 2'd0);
`else
    cyc(); exp_out("t6_beat0", 4'b0100, 1'b1, 2'd2, 2'b10);
    cyc(); exp_out("t6_idle", 4'b0000, 1'b0, 2'd0, 2'd0);
    cyc(); exp_out("t6_beat1", 4'b0100, 1'b1, 2'd2, 2'b10);
`endif
    bus.req = 4'b0000;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 2, width of each data source and of dout.
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per grant when burst mode is compiled in.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  4  request per source, bit i = source i.
REQ-006 SHALL have ports din0..din3  input  DATA_W each  source data.
REQ-007 SHALL have port out_ready  input  1  downstream accepts dout.
REQ-008 SHALL have port gnt  output  4  one-hot grant, all zero when idle.
REQ-009 SHALL have port sel  output  2  registered mux select, encoded index of granted source.
REQ-010 SHALL have port dout  output  DATA_W  selected source data.
REQ-011 SHALL have port out_valid  output  1  dout holds a valid beat.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT.
REQ-013 IDLE: if req != 0, SHALL grant the first requesting index searching upward from ptr with wrap 3->0, register gnt/sel, and enter GRANT.
REQ-014 IDLE with req == 0 SHALL stay in IDLE with gnt=0 and out_valid=0.
REQ-015 GRANT: out_valid SHALL be 1 and dout SHALL combinationally equal din[sel]; request-to-out_valid latency is exactly 1 cycle.
REQ-016 A transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-017 On a transfer without burst continuation, SHALL set ptr = sel+1 (mod 4), clear gnt, and return to IDLE, leaving one idle cycle between grants.
REQ-018 If req[sel] deasserts in GRANT before a transfer, SHALL abort: next cycle IDLE, gnt=0, out_valid=0, ptr unchanged.
REQ-019 When out_ready is low in GRANT, SHALL hold gnt, sel, and state unchanged (no timeout).
REQ-020 Changes on non-granted req bits during GRANT SHALL have no effect.
REQ-021 Behaviour SHALL be fair: no requester waits more than 3 grants while continuously requesting.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state=IDLE, ptr=0, gnt=0, sel=0, out_valid=0, and burst count=0, including mid-grant.
REQ-023 After rst_n deasserts, SHALL begin arbitrating on the first rising edge.

Configuration
REQ-024 Burst mode SHALL be compiled in by macro ARB_BURST_EN.
REQ-025 With ARB_BURST_EN defined: after a transfer with req[sel] still high and beat count < MAX_BURST-1, SHALL stay in GRANT and increment the count; otherwise follow REQ-017 and clear the count.
REQ-026 With ARB_BURST_EN undefined: every grant SHALL be exactly one beat, and no counter SHALL be synthesised.

Structure
REQ-027 Shared package arb_pkg SHALL hold the state enum typedef (IDLE, GRANT), NUM_SRC=4, and SEL_W=2.
REQ-028 The data path SHALL be one sub-module, mux4_data, a 4:1 DATA_W mux driven by sel.
REQ-029 Round-robin search, FSM, and burst counter SHALL reside in rr_mux_arbiter.

Verification
REQ-030 Reset then req=4'b0101, out_ready=1, din0=2'b00, din2=2'b10 -> gnt=0001, dout=00 at cycle 1; idle cycle; then gnt=0100, dout=10.
REQ-031 req=4'b1111 held, out_ready=1, burst off -> grant order 0,1,2,3,0, each separated by one idle cycle.
REQ-032 Grant to source 3, out_ready=0 for 5 cycles -> gnt=1000 and out_valid held; transfer on out_ready=1; next grant to source 0 with wrap.
REQ-033 Grant to source 1, req[1] drops before out_ready -> out_valid=0 next cycle, ptr stays 1, source 1 regranted first on re-request.
REQ-034 rst_n pulled low mid-GRANT -> gnt=0, out_valid=0 asynchronously; first grant after release goes to the lowest requesting index from 0.
REQ-035 ARB_BURST_EN defined, req[2] held, out_ready=1 -> exactly 4 consecutive beats from source 2, then IDLE.
